// File: rtl/div_ratio_ctrl_pkg.sv
// Shared definitions for the run-time clock divider controller:
// FSM state encoding and the ratio legality check.
package div_ratio_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // A ratio is usable when it is non-zero and representable in the counter width.
  function automatic logic ratioLegal(input logic [31:0] n, input int width);
    return (n != 32'd0) && (n < (32'd1 << width));
  endfunction

endpackage

// File: rtl/div_ratio_ctrl_modn_cnt.sv
// Mod-N counter holding the ratio in force; counts 0..N-1 and flags the
// last count of each period so the controller can act on period boundaries.
module div_ratio_ctrl_modn_cnt #(
  parameter int WIDTH = 3,
  parameter int DEF_N = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadN,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_curN,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_curN;
  logic             w_wrap;

  // The ratio is never zero, so curN-1 cannot underflow and cnt stays below curN.
  assign w_wrap = (r_cnt == (r_curN - WIDTH'(1)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_curN <= WIDTH'(DEF_N);
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_run) begin
        r_cnt <= w_wrap ? '0 : r_cnt + WIDTH'(1);
      end
      if (i_load) begin
        r_curN <= i_loadN;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_curN = r_curN;
  assign o_wrap = w_wrap;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run-time controller for the integer clock divider: accepts new ratios over
// valid/ready and applies ratio changes and start/stop only on period boundaries.
module div_ratio_ctrl
  import div_ratio_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEF_N = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [WIDTH-1:0] i_cfg_n,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_tick,
  output logic             o_div_out,
  output logic [WIDTH-1:0] o_cur_n,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_pendNext;
  logic             r_pendValid;
  logic             w_pendValidNext;
  logic             r_tick;
  logic             r_divOut;
  logic             r_cfgReady;
  logic             r_cfgErr;
  logic             r_busy;

  logic             w_load;
  logic [WIDTH-1:0] w_loadN;
  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH-1:0] w_curN;
  logic             w_wrap;
  logic             w_counting;
  logic             w_xfer;
  logic             w_legal;
  logic             w_accept;
  logic             w_reject;
  logic             w_keepRunning;

  assign w_counting    = (r_state != ST_IDLE);
  assign w_xfer        = i_cfg_valid && r_cfgReady;
  assign w_legal       = ratioLegal(32'(i_cfg_n), WIDTH);
  assign w_accept      = w_xfer && w_legal;
  assign w_reject      = w_xfer && !w_legal;
  assign w_keepRunning = w_counting && (w_nextState != ST_IDLE);

  div_ratio_ctrl_modn_cnt #(
    .WIDTH (WIDTH),
    .DEF_N (DEF_N)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst_n),
    .i_clear (r_state == ST_IDLE),
    .i_run   (w_counting),
    .i_load  (w_load),
    .i_loadN (w_loadN),
    .o_cnt   (w_cnt),
    .o_curN  (w_curN),
    .o_wrap  (w_wrap)
  );

  // RUN, PEND and DRAIN count identically; they differ only in what happens at a wrap.
  always_comb begin
    w_nextState     = r_state;
    w_pendNext      = r_pend;
    w_pendValidNext = r_pendValid;
    w_load          = 1'b0;
    w_loadN         = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load  = 1'b1;
          w_loadN = i_cfg_n;
        end
        if (i_en) begin
          w_nextState = ST_RUN;
        end
      end
      default: begin
        if (w_wrap && !i_en) begin
          w_nextState     = ST_IDLE;
          w_pendValidNext = 1'b0;
          if (r_pendValid) begin
            w_load  = 1'b1;
            w_loadN = r_pend;
          end else if (w_accept) begin
            w_load  = 1'b1;
            w_loadN = i_cfg_n;
          end
        end else if (w_wrap && r_pendValid) begin
          w_load          = 1'b1;
          w_loadN         = r_pend;
          w_pendValidNext = 1'b0;
          w_nextState     = ST_RUN;
        end else begin
          if (w_accept) begin
            w_pendNext      = i_cfg_n;
            w_pendValidNext = 1'b1;
          end
          if (!i_en) begin
            w_nextState = ST_DRAIN;
          end else if (w_pendValidNext) begin
            w_nextState = ST_PEND;
          end else begin
            w_nextState = ST_RUN;
          end
        end
      end
    endcase
  end

  // Outputs are forced low on the cycle that lands in IDLE so no partial period leaks out.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_tick      <= 1'b0;
      r_divOut    <= 1'b0;
      r_cfgReady  <= 1'b1;
      r_cfgErr    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_pend      <= w_pendNext;
      r_pendValid <= w_pendValidNext;
      r_tick      <= w_keepRunning && w_wrap;
      r_divOut    <= w_keepRunning && (w_cnt >= (w_curN >> 1));
      r_cfgReady  <= !w_pendValidNext;
      r_cfgErr    <= w_reject;
      r_busy      <= (w_nextState != ST_IDLE);
    end
  end

  assign o_cfg_ready = r_cfgReady;
  assign o_cfg_err   = r_cfgErr;
  assign o_tick      = r_tick;
  assign o_div_out   = r_divOut;
  assign o_cur_n     = w_curN;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl: per-cycle vectors with expected
// registered outputs, queued when driven and compared after the clock edge.
module tb_div_ratio_ctrl;

  localparam int WIDTH = 3;
  localparam int DEF_N = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfgValid = 1'b0;
  logic [WIDTH-1:0] cfgN = '0;
  logic             cfgReady;
  logic             cfgErr;
  logic             tick;
  logic             divOut;
  logic [WIDTH-1:0] curN;
  logic             busy;

  typedef struct {
    logic             en;
    logic             vld;
    logic [WIDTH-1:0] n;
    logic             tick;
    logic             div;
    logic [WIDTH-1:0] curN;
    logic             ready;
    logic             err;
    logic             busy;
  } vec_t;

  typedef struct {
    logic             tick;
    logic             div;
    logic [WIDTH-1:0] curN;
    logic             ready;
    logic             err;
    logic             busy;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  div_ratio_ctrl #(
    .WIDTH (WIDTH),
    .DEF_N (DEF_N)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_en        (en),
    .i_cfg_valid (cfgValid),
    .i_cfg_n     (cfgN),
    .o_cfg_ready (cfgReady),
    .o_cfg_err   (cfgErr),
    .o_tick      (tick),
    .o_div_out   (divOut),
    .o_cur_n     (curN),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic e, input logic v, input logic [WIDTH-1:0] n,
                     input logic t, input logic d, input logic [WIDTH-1:0] c,
                     input logic r, input logic er, input logic b);
    vec_t x;
    x.en = e; x.vld = v; x.n = n;
    x.tick = t; x.div = d; x.curN = c; x.ready = r; x.err = er; x.busy = b;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
      return;
    end
    e = expQ.pop_front();
    check("tick",      idx, 8'(tick),     8'(e.tick));
    check("div_out",   idx, 8'(divOut),   8'(e.div));
    check("cur_n",     idx, 8'(curN),     8'(e.curN));
    check("cfg_ready", idx, 8'(cfgReady), 8'(e.ready));
    check("cfg_err",   idx, 8'(cfgErr),   8'(e.err));
    check("busy",      idx, 8'(busy),     8'(e.busy));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    en       = v.en;
    cfgValid = v.vld;
    cfgN     = v.n;
    e.tick = v.tick; e.div = v.div; e.curN = v.curN;
    e.ready = v.ready; e.err = v.err; e.busy = v.busy;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  task automatic runTable(input int base);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], base + i);
    end
    vecs.delete();
  endtask

  task automatic expectReset(input int idx);
    exp_t e;
    e.tick = 1'b0; e.div = 1'b0; e.curN = WIDTH'(DEF_N);
    e.ready = 1'b1; e.err = 1'b0; e.busy = 1'b0;
    expQ.push_back(e);
    checkOutput(idx);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expectReset(1000);
    @(negedge clk);
    rst = 1'b0;

    // N=5 from reset, then change to 3 mid-period
    add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1);
    add(1,0,0, 0,1,5,1,0,1); add(1,0,0, 0,1,5,1,0,1); add(1,0,0, 1,1,5,1,0,1);
    add(1,0,0, 0,0,5,1,0,1); add(1,1,3, 0,0,5,0,0,1); add(1,0,0, 0,1,5,0,0,1);
    add(1,0,0, 0,1,5,0,0,1); add(1,0,0, 1,1,3,1,0,1); add(1,0,0, 0,0,3,1,0,1);
    add(1,0,0, 0,1,3,1,0,1); add(1,0,0, 1,1,3,1,0,1); add(1,0,0, 0,0,3,1,0,1);
    // zero ratio rejected, then a transfer on the wrap cycle
    add(1,1,0, 0,1,3,1,1,1); add(1,0,0, 1,1,3,1,0,1); add(1,0,0, 0,0,3,1,0,1);
    add(1,0,0, 0,1,3,1,0,1); add(1,1,4, 1,1,3,0,0,1); add(1,0,0, 0,0,3,0,0,1);
    add(1,0,0, 0,1,3,0,0,1); add(1,0,0, 1,1,4,1,0,1); add(1,0,0, 0,0,4,1,0,1);
    add(1,0,0, 0,0,4,1,0,1); add(1,0,0, 0,1,4,1,0,1); add(1,0,0, 1,1,4,1,0,1);
    add(1,1,5, 0,0,4,0,0,1); add(1,0,0, 0,0,4,0,0,1); add(1,0,0, 0,1,4,0,0,1);
    add(1,0,0, 1,1,5,1,0,1); add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1);
    // stop at cnt=2, drain to IDLE
    add(0,0,0, 0,1,5,1,0,1); add(0,0,0, 0,1,5,1,0,1); add(0,0,0, 0,0,5,1,0,0);
    add(0,0,0, 0,0,5,1,0,0);
    // restart, brief drain cancelled by en=1
    add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1);
    add(0,0,0, 0,1,5,1,0,1); add(1,0,0, 0,1,5,1,0,1); add(1,0,0, 1,1,5,1,0,1);
    add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,1,5,1,0,1);
    add(1,0,0, 0,1,5,1,0,1); add(1,0,0, 1,1,5,1,0,1);
    add(0,0,0, 0,0,5,1,0,1); add(0,0,0, 0,0,5,1,0,1); add(0,0,0, 0,1,5,1,0,1);
    add(0,0,0, 0,1,5,1,0,1); add(0,0,0, 0,0,5,1,0,0);
    // ratio 7 loaded from IDLE together with en
    add(1,1,7, 0,0,7,1,0,1); add(1,0,0, 0,0,7,1,0,1); add(1,0,0, 0,0,7,1,0,1);
    add(1,0,0, 0,0,7,1,0,1); add(1,0,0, 0,1,7,1,0,1); add(1,0,0, 0,1,7,1,0,1);
    add(1,0,0, 0,1,7,1,0,1); add(1,0,0, 1,1,7,1,0,1); add(1,0,0, 0,0,7,1,0,1);
    // ratio 1: tick and div_out held high
    add(1,1,1, 0,0,7,0,0,1); add(1,0,0, 0,0,7,0,0,1); add(1,0,0, 0,1,7,0,0,1);
    add(1,0,0, 0,1,7,0,0,1); add(1,0,0, 0,1,7,0,0,1); add(1,0,0, 1,1,1,1,0,1);
    add(1,0,0, 1,1,1,1,0,1); add(1,0,0, 1,1,1,1,0,1); add(1,0,0, 1,1,1,1,0,1);
    add(1,1,6, 1,1,1,0,0,1); add(1,0,0, 1,1,6,1,0,1);
    // enter PEND with ratio 2 queued
    add(1,1,2, 0,0,6,0,0,1); add(1,0,0, 0,0,6,0,0,1); add(1,0,0, 0,0,6,0,0,1);
    add(1,0,0, 0,1,6,0,0,1);
    runTable(0);

    // asynchronous reset mid-PEND, between clock edges
    @(negedge clk);
    en = 1'b0;
    cfgValid = 1'b0;
    cfgN = '0;
    #2 rst = 1'b1;
    #1 expectReset(2000);
    @(posedge clk);
    #1 expectReset(2001);
    @(negedge clk);
    rst = 1'b0;

    // pending ratio 2 must be gone: period stays 5
    add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1); add(1,0,0, 0,0,5,1,0,1);
    add(1,0,0, 0,1,5,1,0,1); add(1,0,0, 0,1,5,1,0,1); add(1,0,0, 1,1,5,1,0,1);
    add(1,0,0, 0,0,5,1,0,1);
    runTable(3000);

    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d leftover entries, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
